// File: rtl/seq_det_event_logger_if.sv
// -----------------------------------------------------------------------------
// seq_det_event_logger_if
//   Valid/ready event port carrying one timestamp per transfer from the event
//   logger (master) to its consumer (slave).
//
// Parameters
//   TS_W       timestamp width in bits
//
// Signals
//   evt_data   TS_W  timestamp at the head of the logger FIFO
//   evt_valid  1     evt_data holds a valid entry
//   evt_ready  1     consumer accepts the head entry this cycle
// -----------------------------------------------------------------------------
interface seq_det_event_logger_if #(
    parameter int TS_W = 16
);
    logic [TS_W-1:0] evt_data;
    logic            evt_valid;
    logic            evt_ready;

    modport master (
        output evt_data,
        output evt_valid,
        input  evt_ready
    );

    modport slave (
        input  evt_data,
        input  evt_valid,
        output evt_ready
    );
endinterface

// File: rtl/seq_det_event_logger.sv
// -----------------------------------------------------------------------------
// seq_det_event_logger
//   Consumes the yout pulse of the Mealy sequence detector. Every cycle with
//   det_in high is one event: it is stamped with a free-running cycle counter
//   and queued in a FIFO that the consumer drains over a valid/ready port.
//   A saturating event counter and a sticky overflow flag are kept alongside.
//
// Build option
//   SEQ_EVT_IRQ_EN  when defined, adds parameter IRQ_THRESH and output irq: a
//                   single-cycle pulse the cycle after evt_count first equals
//                   IRQ_THRESH, not retriggering until reset/clr.
//
// Parameters
//   TS_W        timestamp width; the stamp counter wraps modulo 2^TS_W
//   DEPTH       FIFO entries, power of two, >= 2
//   CNT_W       width of the saturating event counter
//   IRQ_THRESH  event count that raises irq (SEQ_EVT_IRQ_EN only)
//
// Ports
//   clk         in   rising-edge clock
//   reset_n     in   synchronous reset, active low, overrides all inputs
//   det_in      in   detection pulse from the sequence detector
//   clr         in   synchronous soft clear, same effect as reset
//   evt         master modport: evt_data / evt_valid out, evt_ready in
//   evt_count   out  events seen since reset/clr, saturating
//   fifo_level  out  entries currently held, 0..DEPTH
//   overflow    out  sticky: an event was dropped on a full FIFO
//   irq         out  threshold pulse (SEQ_EVT_IRQ_EN only)
//
// All outputs are registered; det_in and evt_ready only reach flops.
// -----------------------------------------------------------------------------
module seq_det_event_logger #(
    parameter int TS_W  = 16,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
`ifdef SEQ_EVT_IRQ_EN
    ,
    parameter int IRQ_THRESH = 16
`endif
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     det_in,
    input  logic                     clr,
    seq_det_event_logger_if.master   evt,
    output logic [CNT_W-1:0]         evt_count,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow
`ifdef SEQ_EVT_IRQ_EN
    ,
    output logic                     irq
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [TS_W-1:0] ts;
    logic [TS_W-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   rd_next;
    logic            pop;
    logic            full;
    logic            push_ok;
    logic            drop;
    logic [LW-1:0]   level_after_pop;
    logic [LW-1:0]   level_next;
    logic [TS_W-1:0] head_next;

    // Next-state of the FIFO. evt_data is a register, so the value the head
    // will hold after this edge is worked out here from the current contents.
    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        pop             = evt.evt_valid && evt.evt_ready;
        full            = (fifo_level == LW'(DEPTH));
        // A pop in the same cycle frees a slot, so a full FIFO still accepts.
        push_ok         = det_in && (!full || pop);
        drop            = det_in && full && !pop;
        level_after_pop = fifo_level - LW'(pop);
        level_next      = level_after_pop + LW'(push_ok);
        rd_next         = rd_ptr + AW'(pop);
        head_next       = '0;
        if (push_ok && (level_after_pop == '0)) begin
            // FIFO is (or becomes) empty: the new stamp goes straight to the
            // head, bypassing the memory it is written into this same edge.
            head_next = ts;
        end else if (level_next != '0) begin
            head_next = mem[rd_next];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            ts            <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_level    <= '0;
            evt.evt_valid <= 1'b0;
            evt.evt_data  <= '0;
            evt_count     <= '0;
            overflow      <= 1'b0;
        end else begin
            ts            <= ts + TS_W'(1);
            rd_ptr        <= rd_next;
            fifo_level    <= level_next;
            evt.evt_valid <= (level_next != '0);
            evt.evt_data  <= head_next;
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            // Counter tracks every event, including ones dropped on overflow.
            if (det_in && (evt_count != '1)) begin
                evt_count <= evt_count + CNT_W'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // NOTE: the storage array has no reset; validity is carried entirely by
    // the pointers and level, and leaving it unreset lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (reset_n && !clr && push_ok) begin
            mem[wr_ptr] <= ts;
        end
    end

`ifdef SEQ_EVT_IRQ_EN
    logic irq_done;

    // Compares the registered count, so the pulse lands the cycle after the
    // count first shows IRQ_THRESH; irq_done blocks any retrigger.
    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            irq      <= 1'b0;
            irq_done <= 1'b0;
        end else begin
            irq <= 1'b0;
            if (!irq_done && (evt_count == CNT_W'(IRQ_THRESH))) begin
                irq      <= 1'b1;
                irq_done <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_seq_det_event_logger.sv
// -----------------------------------------------------------------------------
// tb_seq_det_event_logger
//   Directed bench for seq_det_event_logger. The main instance uses the
//   default sizes (TS_W=16, DEPTH=8, CNT_W=16); a second, narrow instance
//   (TS_W=4, DEPTH=4, CNT_W=3) shows timestamp wrap and counter saturation.
//   Inputs change 1 time unit after a rising edge; outputs are read there too.
// -----------------------------------------------------------------------------
module tb_seq_det_event_logger;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        det_in = 1'b0;
    logic        det4 = 1'b0;
    logic        clr = 1'b0;

    logic [15:0] evt_count;
    logic [3:0]  fifo_level;
    logic        overflow;
    logic [2:0]  evt_count4;
    logic [2:0]  fifo_level4;
    logic        overflow4;
`ifdef SEQ_EVT_IRQ_EN
    logic        irq;
    logic        irq4;
`endif

    int errors = 0;
    int checks = 0;
    int ts_m   = 0;

    seq_det_event_logger_if #(.TS_W(16)) evt_if ();
    seq_det_event_logger_if #(.TS_W(4))  evt4_if ();

    seq_det_event_logger #(
        .TS_W(16), .DEPTH(8), .CNT_W(16)
`ifdef SEQ_EVT_IRQ_EN
        , .IRQ_THRESH(4)
`endif
    ) dut (
        .clk(clk), .reset_n(reset_n), .det_in(det_in), .clr(clr),
        .evt(evt_if.master), .evt_count(evt_count), .fifo_level(fifo_level),
        .overflow(overflow)
`ifdef SEQ_EVT_IRQ_EN
        , .irq(irq)
`endif
    );

    seq_det_event_logger #(
        .TS_W(4), .DEPTH(4), .CNT_W(3)
`ifdef SEQ_EVT_IRQ_EN
        , .IRQ_THRESH(2)
`endif
    ) dut4 (
        .clk(clk), .reset_n(reset_n), .det_in(det4), .clr(clr),
        .evt(evt4_if.master), .evt_count(evt_count4), .fifo_level(fifo_level4),
        .overflow(overflow4)
`ifdef SEQ_EVT_IRQ_EN
        , .irq(irq4)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        ts_m++;
    endtask

    // Soft clear; afterwards both stamp counters read 0.
    task automatic do_clear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        ts_m = 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        det_in = 1'b1;
        evt_if.evt_ready = 1'b1;
        evt4_if.evt_ready = 1'b1;
        tick();
        tick();
        checks++; if (evt_if.evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", evt_if.evt_valid); end
        checks++; if (evt_if.evt_data !== 16'd0) begin errors++; $display("FAIL reset_data: got %0d expected 0", evt_if.evt_data); end
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
        checks++; if (evt_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", evt_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
`ifdef SEQ_EVT_IRQ_EN
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %0b expected 0", irq); end
`endif
        det_in = 1'b0;
        evt_if.evt_ready = 1'b0;
        reset_n = 1'b1;
        ts_m = 0;
        repeat (20) tick();
        checks++; if (dut.ts !== 16'd20) begin errors++; $display("FAIL idle_ts: got %0d expected 20", dut.ts); end
        checks++; if (evt_if.evt_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %0b expected 0", evt_if.evt_valid); end
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL idle_level: got %0d expected 0", fifo_level); end
        checks++; if (evt_count !== 16'd0) begin errors++; $display("FAIL idle_count: got %0d expected 0", evt_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL idle_overflow: got %0b expected 0", overflow); end
    endtask

    task automatic test_basic();
        do_clear();
        evt_if.evt_ready = 1'b1;
        repeat (5) tick();
        det_in = 1'b1;
        tick();
        det_in = 1'b0;
        checks++; if (evt_if.evt_valid !== 1'b1) begin errors++; $display("FAIL basic_valid0: got %0b expected 1", evt_if.evt_valid); end
        checks++; if (evt_if.evt_data !== 16'd5) begin errors++; $display("FAIL basic_data0: got %0d expected 5", evt_if.evt_data); end
        checks++; if (fifo_level !== 4'd1) begin errors++; $display("FAIL basic_level0: got %0d expected 1", fifo_level); end
        tick();
        checks++; if (evt_if.evt_valid !== 1'b0) begin errors++; $display("FAIL basic_popped0: got %0b expected 0", evt_if.evt_valid); end
        repeat (2) tick();
        det_in = 1'b1;
        tick();
        det_in = 1'b0;
        checks++; if (evt_if.evt_valid !== 1'b1) begin errors++; $display("FAIL basic_valid1: got %0b expected 1", evt_if.evt_valid); end
        checks++; if (evt_if.evt_data !== 16'd9) begin errors++; $display("FAIL basic_data1: got %0d expected 9", evt_if.evt_data); end
        tick();
        checks++; if (evt_if.evt_valid !== 1'b0) begin errors++; $display("FAIL basic_popped1: got %0b expected 0", evt_if.evt_valid); end
        checks++; if (evt_count !== 16'd2) begin errors++; $display("FAIL basic_count: got %0d expected 2", evt_count); end
        evt_if.evt_ready = 1'b0;
    endtask

    task automatic test_overflow();
        do_clear();
        evt_if.evt_ready = 1'b0;
        det_in = 1'b1;
        repeat (10) tick();
        det_in = 1'b0;
        checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL ovf_level: got %0d expected 8", fifo_level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b expected 1", overflow); end
        checks++; if (evt_count !== 16'd10) begin errors++; $display("FAIL ovf_count: got %0d expected 10", evt_count); end
        // Head must hold still while the consumer stalls.
        tick();
        checks++; if (evt_if.evt_data !== 16'd0) begin errors++; $display("FAIL ovf_stall_data: got %0d expected 0", evt_if.evt_data); end
        evt_if.evt_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_data !== 16'(i)) begin errors++; $display("FAIL ovf_drain%0d: got valid=%0b data=%0d expected valid=1 data=%0d", i, evt_if.evt_valid, evt_if.evt_data, i); end
            tick();
        end
        checks++; if (evt_if.evt_valid !== 1'b0 || fifo_level !== 4'd0) begin errors++; $display("FAIL ovf_empty: got valid=%0b level=%0d expected 0/0", evt_if.evt_valid, fifo_level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0b expected 1", overflow); end
        evt_if.evt_ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        do_clear();
        evt_if.evt_ready = 1'b0;
        det_in = 1'b1;
        repeat (8) tick();
        checks++; if (fifo_level !== 4'd8 || overflow !== 1'b0) begin errors++; $display("FAIL fpp_filled: got level=%0d ovf=%0b expected 8/0", fifo_level, overflow); end
        evt_if.evt_ready = 1'b1;
        tick();
        det_in = 1'b0;
        checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL fpp_level: got %0d expected 8", fifo_level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_overflow: got %0b expected 0", overflow); end
        checks++; if (evt_if.evt_data !== 16'd1) begin errors++; $display("FAIL fpp_head: got %0d expected 1", evt_if.evt_data); end
        for (int i = 1; i <= 8; i++) begin
            checks++; if (evt_if.evt_data !== 16'(i)) begin errors++; $display("FAIL fpp_drain%0d: got %0d expected %0d", i, evt_if.evt_data, i); end
            tick();
        end
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL fpp_empty: got %0d expected 0", fifo_level); end
        evt_if.evt_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_clear();
        evt_if.evt_ready = 1'b1;
        det_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (evt_if.evt_data !== 16'(k) || fifo_level !== 4'd1) begin errors++; $display("FAIL b2b_%0d: got data=%0d level=%0d expected data=%0d level=1", k, evt_if.evt_data, fifo_level, k); end
        end
        det_in = 1'b0;
        tick();
        checks++; if (evt_if.evt_valid !== 1'b0 || evt_count !== 16'd4) begin errors++; $display("FAIL b2b_end: got valid=%0b count=%0d expected 0/4", evt_if.evt_valid, evt_count); end
        evt_if.evt_ready = 1'b0;
    endtask

    task automatic test_clear();
        do_clear();
        evt_if.evt_ready = 1'b0;
        det_in = 1'b1;
        repeat (3) tick();
        checks++; if (fifo_level !== 4'd3) begin errors++; $display("FAIL clr_pre_level: got %0d expected 3", fifo_level); end
        clr = 1'b1;
        evt_if.evt_ready = 1'b1;
        tick();
        clr = 1'b0;
        det_in = 1'b0;
        evt_if.evt_ready = 1'b0;
        ts_m = 0;
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL clr_level: got %0d expected 0", fifo_level); end
        checks++; if (evt_count !== 16'd0) begin errors++; $display("FAIL clr_count: got %0d expected 0", evt_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_overflow: got %0b expected 0", overflow); end
        checks++; if (evt_if.evt_valid !== 1'b0 || evt_if.evt_data !== 16'd0) begin errors++; $display("FAIL clr_port: got valid=%0b data=%0d expected 0/0", evt_if.evt_valid, evt_if.evt_data); end
        tick();
        checks++; if (fifo_level !== 4'd0 || evt_if.evt_valid !== 1'b0) begin errors++; $display("FAIL clr_not_logged: got level=%0d valid=%0b expected 0/0", fifo_level, evt_if.evt_valid); end
        checks++; if (dut.ts !== 16'd1) begin errors++; $display("FAIL clr_ts: got %0d expected 1", dut.ts); end
    endtask

    task automatic test_wrap();
        do_clear();
        evt4_if.evt_ready = 1'b1;
        repeat (14) tick();
        det4 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (evt4_if.evt_valid !== 1'b1 || evt4_if.evt_data !== 4'((14 + k) % 16)) begin errors++; $display("FAIL wrap_%0d: got valid=%0b data=%0d expected valid=1 data=%0d", k, evt4_if.evt_valid, evt4_if.evt_data, (14 + k) % 16); end
        end
        det4 = 1'b0;
        tick();
        checks++; if (evt4_if.evt_valid !== 1'b0 || evt_count4 !== 3'd3) begin errors++; $display("FAIL wrap_end: got valid=%0b count=%0d expected 0/3", evt4_if.evt_valid, evt_count4); end
        checks++; if (dut4.ts !== 4'(ts_m % 16)) begin errors++; $display("FAIL wrap_ts: got %0d expected %0d", dut4.ts, ts_m % 16); end
    endtask

    task automatic test_saturate();
        do_clear();
        evt4_if.evt_ready = 1'b1;
        det4 = 1'b1;
        repeat (10) tick();
        det4 = 1'b0;
        checks++; if (evt_count4 !== 3'd7) begin errors++; $display("FAIL sat_count: got %0d expected 7", evt_count4); end
        checks++; if (overflow4 !== 1'b0) begin errors++; $display("FAIL sat_overflow: got %0b expected 0", overflow4); end
    endtask

`ifdef SEQ_EVT_IRQ_EN
    task automatic test_irq();
        int pulses = 0;
        int first = -1;
        do_clear();
        evt_if.evt_ready = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            det_in = (k <= 6);
            tick();
            if (irq === 1'b1) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
        det_in = 1'b0;
        checks++; if (pulses !== 1) begin errors++; $display("FAIL irq_pulses: got %0d expected 1", pulses); end
        checks++; if (first !== 5) begin errors++; $display("FAIL irq_cycle: got %0d expected 5", first); end
        evt_if.evt_ready = 1'b0;
    endtask
`endif

    initial begin
        evt_if.evt_ready = 1'b0;
        evt4_if.evt_ready = 1'b1;
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_clear();
        test_wrap();
        test_saturate();
`ifdef SEQ_EVT_IRQ_EN
        test_irq();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
